// File: rtl/execucao_pkg.sv
// Shared definitions for the execute/memory/write-back stage.
// Latency: n/a (types, constants and the instruction decoder only).
// Backpressure: n/a.
// Contents: opcode and funct constants, FSM state encoding, ALU-op enum,
//           decoded-control struct and the decode() helper.
package execucao_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {IDLE, EX, MEM, WB} state_t;

  typedef enum logic [1:0] {ADD, SUB, XOR, SRL} alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    use_imm;    // operand B is sext(immediate) instead of rs2
    logic    is_load;
    logic    is_store;
    logic    is_branch;
    logic    reg_write;
    logic    illegal;
  } ctrl_t;

  // Illegal encodings come back with every side-effect flag cleared, so
  // they flow through the stage as a NOP.
  function automatic ctrl_t decode(input logic [6:0] op,
                                   input logic [2:0] f3,
                                   input logic [6:0] f7);
    ctrl_t c;
    c         = '0;
    c.alu_op  = ADD;
    c.illegal = 1'b1;
    case (op)
      OP_RTYPE: begin
        if (f3 == F3_ADD_SUB && f7 == F7_BASE) begin
          c.alu_op = ADD; c.reg_write = 1'b1; c.illegal = 1'b0;
        end else if (f3 == F3_ADD_SUB && f7 == F7_SUB) begin
          c.alu_op = SUB; c.reg_write = 1'b1; c.illegal = 1'b0;
        end else if (f3 == F3_XOR && f7 == F7_BASE) begin
          c.alu_op = XOR; c.reg_write = 1'b1; c.illegal = 1'b0;
        end else if (f3 == F3_SRL && f7 == F7_BASE) begin
          c.alu_op = SRL; c.reg_write = 1'b1; c.illegal = 1'b0;
        end
      end
      OP_IMM: if (f3 == F3_ADDI) begin
        c.use_imm = 1'b1; c.reg_write = 1'b1; c.illegal = 1'b0;
      end
      OP_LOAD: if (f3 == F3_WORD) begin
        c.use_imm = 1'b1; c.is_load = 1'b1; c.reg_write = 1'b1; c.illegal = 1'b0;
      end
      OP_STORE: if (f3 == F3_WORD) begin
        c.use_imm = 1'b1; c.is_store = 1'b1; c.illegal = 1'b0;
      end
      OP_BRANCH: if (f3 == F3_BEQ) begin
        c.is_branch = 1'b1; c.illegal = 1'b0;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/banco_registradores.sv
// 32x32 register file, x0 hard-wired to zero.
// Latency: reads combinational, write lands on the rising edge.
// Backpressure: none; the write port is always accepted.
// Ports: clk, rst (async active-high, clears all entries); ra1/rd1 and
//        ra2/rd2 operand reads; dbg_addr/dbg_data debug read; we/wa/wd write.
module banco_registradores (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  output logic [31:0] rd1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1      = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2      = (ra2 == 5'd0) ? '0 : regs[ra2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/execucao.sv
// Multi-cycle EX/MEM/WB stage (lw, sw, add, sub, xor, srl, addi, beq); owns regfile and dmem.
// Latency: accept at edge N, done high in cycle N+3, next accept at edge N+4.
// Backpressure: in_ready low while busy; with ILLEGAL_TRAP_EN an illegal op holds it low until rst.
// Ports: clk, rst (async active-high); in_valid/in_ready handshake with opcode, rd, rs1,
//        rs2, funct3, funct7, immediate, pc; done/branch_taken/branch_target/illegal
//        retirement report (WB cycle only); trap sticky flag; dbg_addr/dbg_data.
// Optional feature macro: ILLEGAL_TRAP_EN (sticky trap on illegal instructions).
module execucao
  import execucao_pkg::*;
#(
  parameter int DMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] immediate,
  input  logic [31:0] pc,
  output logic        done,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        illegal,
  output logic        trap,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int AW = $clog2(DMEM_WORDS);

  state_t      state, state_nxt;
  ctrl_t       ctrl_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [11:0] imm_q;
  logic [31:0] pc_q;
  logic [31:0] alu_q, sdata_q, ldata_q;
  logic        eq_q;

  logic [31:0] rs1_val, rs2_val, simm, opb, alu_res, wd;
  logic        accept, we;
  logic [AW-1:0] widx;

  logic [31:0] dmem [DMEM_WORDS];

  assign accept = in_valid && in_ready;
  assign simm   = {{20{imm_q[11]}}, imm_q};
  assign opb    = ctrl_q.use_imm ? simm : rs2_val;
  // Low two address bits are dropped and anything above the array wraps.
  assign widx   = alu_q[AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EX;
      EX:      state_nxt = MEM;
      MEM:     state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (ctrl_q.alu_op)
      ADD: alu_res = rs1_val + opb;
      SUB: alu_res = rs1_val - opb;
      XOR: alu_res = rs1_val ^ opb;
      SRL: alu_res = rs1_val >> opb[4:0];
      default: alu_res = '0;
    endcase
  end

  // Datapath registers. Retirement outputs are loaded on the MEM->WB edge so
  // they are high exactly during WB and return to zero on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q        <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      alu_q         <= '0;
      sdata_q       <= '0;
      ldata_q       <= '0;
      eq_q          <= 1'b0;
      done          <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      illegal       <= 1'b0;
    end else begin
      if (accept) begin
        ctrl_q <= decode(opcode, funct3, funct7);
        rd_q   <= rd;
        rs1_q  <= rs1;
        rs2_q  <= rs2;
        imm_q  <= immediate;
        pc_q   <= pc;
      end
      if (state == EX) begin
        alu_q   <= alu_res;
        eq_q    <= (rs1_val == rs2_val);
        sdata_q <= rs2_val;
      end
      if (state == MEM) ldata_q <= dmem[widx];
      done          <= (state == MEM);
      branch_taken  <= (state == MEM) && ctrl_q.is_branch && eq_q;
      branch_target <= (state == MEM) ? pc_q + (simm << 1) : '0;
      illegal       <= (state == MEM) && ctrl_q.illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    end else if (state == MEM && ctrl_q.is_store) begin
      dmem[widx] <= sdata_q;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                trap <= 1'b0;
    else if (state == WB && ctrl_q.illegal) trap <= 1'b1;
  end
`else
  assign trap = 1'b0;
`endif

  assign in_ready = (state == IDLE) && !trap;

  assign we = (state == WB) && ctrl_q.reg_write;
  assign wd = ctrl_q.is_load ? ldata_q : alu_q;

  banco_registradores u_regs (
    .clk      (clk),
    .rst      (rst),
    .ra1      (rs1_q),
    .rd1      (rs1_val),
    .ra2      (rs2_q),
    .rd2      (rs2_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (we),
    .wa       (rd_q),
    .wd       (wd)
  );

endmodule

// File: doc/execucao.md
# execucao

Multi-cycle execute/memory/write-back stage of the RISC-V datapath, directly downstream of instruction decode and control. It accepts one decoded instruction per handshake and sequences it through EX, MEM and WB. It owns the register file and the data memory, and it reports retirement and branch outcome back to the PC logic. It supports lw, sw, add, sub, xor, srl, addi and beq.

## Interface
- DMEM_WORDS, 32: data-memory depth in 32-bit words; must be a power of two.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction fields are valid.
- in_ready  out  1  stage is idle and can accept an instruction.
- opcode  in  7  instruction opcode.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3 / funct7  in  7  function fields.
- immediate  in  12  immediate already assembled by decode; for beq this is imm[12:1].
- pc  in  32  byte address of the instruction.
- done  out  1  one-cycle pulse when the instruction retires.
- branch_taken  out  1  beq condition true; valid only with done.
- branch_target  out  32  pc + (sext(immediate) << 1); valid only with done.
- illegal  out  1  unsupported encoding; valid only with done.
- trap  out  1  sticky illegal-instruction flag (see Configuration).
- dbg_addr  in  5 / dbg_data  out  32  combinational register-file read port for the bench; x0 always reads 0.

## Operation
- FSM states: IDLE, EX, MEM, WB.
  - IDLE→EX on in_valid && in_ready; all input fields and pc are latched at that edge.
  - EX→MEM, MEM→WB and WB→IDLE are unconditional.
- in_ready = (state == IDLE) && !trap.
- EX: read rs1/rs2 and register the ALU result plus the beq compare.
  - add/addi: sum. sub: rs1 − rs2. All arithmetic is modulo 2^32.
  - xor: bitwise. srl: logical shift right by rs2[4:0].
  - lw/sw address: rs1 + sext(imm).
- Decoding:
  - R-type 0110011: add is f3 000/f7 0000000; sub is f3 000/f7 0100000; xor is f3 100/f7 0; srl is f3 101/f7 0.
  - addi is 0010011/f3 000. lw is 0000011/f3 010. sw is 0100011/f3 010. beq is 1100011/f3 000.
  - Any other encoding is illegal.
- MEM:
  - Word index = addr[log2(DMEM_WORDS)+1:2]. Low two bits are ignored; out-of-range addresses wrap.
  - sw writes rs2 at the end of MEM. lw reads the word.
  - Other instructions pass through MEM with no memory effect.
- WB:
  - Write rd at the end of WB for add/sub/xor/srl/addi/lw. The write is discarded when rd == 0.
  - sw, beq and illegal instructions never write the register file.
- Reset clears every register-file entry and every data-memory word to 0 and forces IDLE.

## Timing
- Fixed latency: accept at edge N. The stage is in EX, MEM and WB during cycles N+1, N+2 and N+3, and back in IDLE after edge N+4.
- Throughput is one instruction per 4 cycles. in_ready is low for exactly 3 cycles after acceptance.
- done, branch_taken, branch_target and illegal are registered and high only during the WB cycle. branch_taken, branch_target and illegal read 0 outside WB.
- A register written in WB is visible on dbg_data and to the next instruction's EX. There is no hazard because execution is strictly sequential.
- Reset values: done, branch_taken, branch_target, illegal and trap are 0; in_ready is 1.
- Reset asserted mid-operation aborts the instruction immediately:
  - A pending sw or rd write is not performed.
  - No done is produced.
  - in_ready is 1 in the first cycle after rst deasserts.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An illegal instruction sets trap at its WB edge.
  - trap stays 1 and in_ready stays 0 until rst.
- ILLEGAL_TRAP_EN undefined:
  - trap is tied to 0.
  - An illegal instruction retires as a NOP with a done + illegal pulse, and the stage accepts again.

## Structure
- Package execucao_pkg holds:
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_IMM, OP_BRANCH.
  - funct3/funct7 constants.
  - the FSM state encoding.
  - the internal ALU-operation enum: ADD, SUB, XOR, SRL.
- Sub-module banco_registradores:
  - 32×32 register file with asynchronous reset.
  - two combinational read ports plus the debug port, one write port; x0 hard-wired to 0.
- The data memory is an array inside execucao.

## Test plan
- Reset, then addi x1,x0,5 accepted at edge N → in_ready low for N+1..N+3, done only in N+3, dbg x1 = 5.
- addi x2,x0,0xFFF, then srl x3,x2,x1 → x3 = 0x07FFFFFF. Then sub x4,x1,x2 → x4 = 6. Then xor x5,x1,x2 → x5 = 0xFFFFFFFA.
- sw x1,8(x0), then lw x6,8(x0) → x6 = 5. The sw changes no register. Address 8+4·DMEM_WORDS aliases word 2.
- beq x1,x1 with imm 4, pc 0x10 → branch_taken = 1 and target 0x18 during WB. beq x1,x2 → branch_taken = 0.
- addi x0,x0,7 → x0 still reads 0. Opcode 0x7F → done + illegal pulse, no state change.
  - With ILLEGAL_TRAP_EN: trap = 1 and in_ready stays 0 until rst.
- sw x1,0(x0) with rst pulsed during MEM → word 0 reads 0 afterwards, no done, in_ready = 1 right after reset.
